// File: rtl/rgb_led_pkg.sv
// Shared types, constants and the priority picker for the RGB LED arbiter.
// Index 0 is always the highest-priority requester.
package rgb_led_pkg;

  localparam int MAX_REQ = 32;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  localparam logic LED_OFF = 1'b1;

  // Isolates the lowest set bit, giving a one-hot winner (zero when nobody asks).
  function automatic logic [MAX_REQ-1:0] prio_pick(input logic [MAX_REQ-1:0] req);
    return req & (~req + MAX_REQ'(1));
  endfunction

endpackage

// File: rtl/rgb_pwm.sv
// 8-bit three-channel PWM: prescaler, free-running frame counter and latched duties.
// lit_o is active-high and purely a function of registered state.
module rgb_pwm
  import rgb_led_pkg::*;
#(
  parameter int PWM_DIV = 47
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       latch_i,
  input  color_t     color_i,
  output logic [2:0] lit_o,
  output logic       frame_wrap_o
);

  localparam int PRESC_W = $clog2(PWM_DIV + 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [7:0]         frame_q, frame_d;
  color_t             duty_q,  duty_d;
  logic               prescWrap;

  assign prescWrap    = (presc_q == PRESC_W'(PWM_DIV - 1));
  assign frame_wrap_o = prescWrap && (frame_q == 8'hFF);

  always_comb begin
    presc_d = prescWrap ? '0 : presc_q + PRESC_W'(1);
    frame_d = prescWrap ? frame_q + 8'd1 : frame_q;
    duty_d  = latch_i ? color_i : duty_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      frame_q <= '0;
      duty_q  <= '0;
    end else begin
      presc_q <= presc_d;
      frame_q <= frame_d;
      duty_q  <= duty_d;
    end
  end

  // Strict less-than: duty 0 never lights, duty 255 lights 255 of 256 steps.
  assign lit_o = {frame_q < duty_q.r, frame_q < duty_q.g, frame_q < duty_q.b};

endmodule

// File: rtl/rgb_led_arbiter.sv
// Shares one active-low RGB LED between prioritised requesters with a minimum
// hold time, an off-gap between owners, PWM colour and optional blink.
module rgb_led_arbiter
  import rgb_led_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int PWM_DIV   = 47,
  parameter int BLINK_CYC = 6000000,
  parameter int MIN_HOLD  = 1200000,
  parameter int GAP_CYC   = 12000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [24*NUM_REQ-1:0]  color_i,
  input  logic [NUM_REQ-1:0]     blink_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic                   busy_o,
  output logic                   led_r_o,
  output logic                   led_g_o,
  output logic                   led_b_o
);

  localparam int HOLD_W  = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int BLINK_W = $clog2(BLINK_CYC + 1);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q,   gnt_d;
  logic                 busy_q,  busy_d;
  logic [HOLD_W-1:0]    hold_q,  hold_d;
  logic [GAP_W-1:0]     gap_q,   gap_d;
  logic [BLINK_W-1:0]   bcnt_q,  bcnt_d;
  logic                 phase_q, phase_d;
  logic [2:0]           led_q,   led_d;

  logic [NUM_REQ-1:0]   pick;
  logic [NUM_REQ-1:0]   colorSel;
  logic                 grantNow;
  logic                 ownerReq;
  logic                 ownerBlink;
  logic                 higherReq;
  logic                 holdDone;
  logic                 showLed;
  logic                 ledLatch;
  logic [23:0]          selColorRaw;
  logic [2:0]           lit;
  logic                 frameWrap;

  assign pick       = NUM_REQ'(prio_pick(MAX_REQ'(req_i)));
  assign ownerReq   = |(req_i & gnt_q);
  assign ownerBlink = |(blink_i & gnt_q);
  // gnt_q - 1 sets every bit below the owner, i.e. all higher-priority slots.
  assign higherReq  = |(req_i & (gnt_q - NUM_REQ'(1)));
  assign holdDone   = (hold_q >= HOLD_W'(MIN_HOLD));

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    hold_d   = hold_q;
    gap_d    = gap_q;
    bcnt_d   = bcnt_q;
    phase_d  = phase_q;
    grantNow = 1'b0;
    case (state_q)
      IDLE: grantNow = |req_i;
      GRANT: begin
        if (!ownerReq || (holdDone && higherReq)) begin
          state_d = GAP;
          gnt_d   = '0;
          gap_d   = '0;
        end else if (!holdDone) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        if (bcnt_q == BLINK_W'(BLINK_CYC - 1)) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + BLINK_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          if (|req_i) grantNow = 1'b1;
          else        state_d  = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Leaving the gap re-arbitrates in the same cycle, sharing the idle grant path.
    if (grantNow) begin
      state_d = GRANT;
      gnt_d   = pick;
      hold_d  = '0;
      bcnt_d  = '0;
      phase_d = 1'b1;
    end
  end

  always_comb begin
    colorSel    = grantNow ? pick : gnt_q;
    selColorRaw = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (colorSel[i]) selColorRaw = selColorRaw | color_i[24*i +: 24];
    end
  end

  assign ledLatch = grantNow || (frameWrap && (state_q == GRANT));

  rgb_pwm #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .latch_i      (ledLatch),
    .color_i      (color_t'(selColorRaw)),
    .lit_o        (lit),
    .frame_wrap_o (frameWrap)
  );

  always_comb begin
    showLed = (state_q == GRANT) && (!ownerBlink || phase_q);
    led_d   = ~(lit & {3{showLed}});
    busy_d  = |gnt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      gap_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      led_q   <= {3{LED_OFF}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign gnt_o   = gnt_q;
  assign busy_o  = busy_q;
  assign led_r_o = led_q[2];
  assign led_g_o = led_q[1];
  assign led_b_o = led_q[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Randomised bench for rgb_led_arbiter against a cycle-level behavioural model
// built from ownership age, gap length and frame position arithmetic.
module tb_rgb_led_arbiter;

  localparam int NR = 3;
  localparam int PD = 1;
  localparam int BC = 16;
  localparam int MH = 20;
  localparam int GC = 4;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [24*NR-1:0] color;
  logic [NR-1:0] blink;
  logic [NR-1:0] gnt;
  logic          busy;
  logic          ledR, ledG, ledB;

  int compared   = 0;
  int mismatched = 0;

  // Model state: owner index (-1 none), gap cycles left, ages since grant.
  int   mOwner;
  int   mGap;
  int   mAge;
  int   mBlinkAge;
  int   mTick;
  int   mDuty [3];
  logic [2:0] mLed;
  logic [NR-1:0] mGnt;

  rgb_led_arbiter #(
    .NUM_REQ   (NR),
    .PWM_DIV   (PD),
    .BLINK_CYC (BC),
    .MIN_HOLD  (MH),
    .GAP_CYC   (GC)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .color_i (color),
    .blink_i (blink),
    .gnt_o   (gnt),
    .busy_o  (busy),
    .led_r_o (ledR),
    .led_g_o (ledG),
    .led_b_o (ledB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR-1:0] b);
    req   = r;
    blink = b;
  endtask

  task automatic setColor(input int idx, input logic [23:0] c);
    color[24*idx +: 24] = c;
  endtask

  task automatic modelReset();
    mOwner    = -1;
    mGap      = 0;
    mAge      = 0;
    mBlinkAge = 0;
    mTick     = 0;
    mLed      = 3'b111;
    mGnt      = '0;
    for (int i = 0; i < 3; i++) mDuty[i] = 0;
  endtask

  task automatic loadDuty(input int who);
    logic [23:0] c;
    c = color[24*who +: 24];
    mDuty[0] = int'(c[23:16]);
    mDuty[1] = int'(c[15:8]);
    mDuty[2] = int'(c[7:0]);
  endtask

  // One clock edge of the reference behaviour, using the inputs seen at that edge.
  task automatic modelStep();
    int   frame;
    bit   visible;
    bit   wrapNow;
    bit   higher;
    bit   arb;
    int   winner;
    logic [2:0] lit;
    frame   = (mTick / PD) % 256;
    visible = ((mBlinkAge / BC) % 2) == 0;
    wrapNow = ((mTick + 1) % (256 * PD)) == 0;
    lit     = 3'b000;
    if (mOwner >= 0 && (!blink[mOwner] || visible))
      lit = {frame < mDuty[0], frame < mDuty[1], frame < mDuty[2]};
    mLed = ~lit;
    winner = -1;
    for (int i = NR - 1; i >= 0; i--) if (req[i]) winner = i;
    if (mOwner >= 0) begin
      higher = 1'b0;
      for (int i = 0; i < mOwner; i++) if (req[i]) higher = 1'b1;
      if (!req[mOwner] || (mAge >= MH && higher)) begin
        mOwner = -1;
        mGap   = GC;
      end else begin
        mAge++;
        mBlinkAge++;
        if (wrapNow) loadDuty(mOwner);
      end
    end else begin
      arb = 1'b1;
      if (mGap > 0) begin
        mGap--;
        arb = (mGap == 0);
      end
      if (arb && winner >= 0) begin
        mOwner    = winner;
        mAge      = 0;
        mBlinkAge = 0;
        loadDuty(winner);
      end
    end
    mGnt = (mOwner >= 0) ? NR'(1 << mOwner) : '0;
    mTick++;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("gnt",  32'(gnt),  32'(mGnt));
      checkOutput("busy", 32'(busy), 32'(mGnt != '0));
      checkOutput("leds", 32'({ledR, ledG, ledB}), 32'(mLed));
    end
  endtask

  // Counts lit steps per channel over one full frame while the duty is steady.
  task automatic frameCount(input int expR, input int expG, input int expB);
    int cr, cg, cb;
    cr = 0; cg = 0; cb = 0;
    for (int k = 0; k < 256 * PD; k++) begin
      step(1);
      cr += int'(!ledR);
      cg += int'(!ledG);
      cb += int'(!ledB);
    end
    checkOutput("rLitSteps", 32'(cr), 32'(expR));
    checkOutput("gLitSteps", 32'(cg), 32'(expG));
    checkOutput("bLitSteps", 32'(cb), 32'(expB));
  endtask

  // Asserts reset between edges and checks the pins react without a clock.
  task automatic resetPulse();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstGnt",  32'(gnt), 32'(0));
    checkOutput("rstBusy", 32'(busy), 32'(0));
    checkOutput("rstLeds", 32'({ledR, ledG, ledB}), 32'(3'b111));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin
    int idx;
    rst_n = 1'b0;
    req   = '0;
    blink = '0;
    color = '0;
    modelReset();
    #12;
    checkOutput("initGnt",  32'(gnt), 32'(0));
    checkOutput("initBusy", 32'(busy), 32'(0));
    checkOutput("initLeds", 32'({ledR, ledG, ledB}), 32'(3'b111));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    step(1000);

    $display("[TB] single owner PWM");
    setColor(1, 24'hFF0080);
    applyStimulus(3'b010, 3'b000);
    step(10);
    frameCount(255, 0, 128);
    step(300);
    applyStimulus(3'b000, 3'b000);
    step(8);

    $display("[TB] preemption after hold");
    setColor(2, 24'h30A010);
    setColor(0, 24'h80FF40);
    applyStimulus(3'b100, 3'b000);
    step(6);
    applyStimulus(3'b101, 3'b000);
    step(40);

    $display("[TB] lower priority never preempts");
    step(30);
    applyStimulus(3'b100, 3'b000);
    step(12);

    $display("[TB] blink");
    applyStimulus(3'b000, 3'b000);
    step(6);
    setColor(2, 24'hFFFFFF);
    applyStimulus(3'b100, 3'b100);
    step(80);

    $display("[TB] colour change mid frame");
    applyStimulus(3'b000, 3'b000);
    step(6);
    setColor(2, 24'h004040);
    applyStimulus(3'b100, 3'b000);
    step(100);
    setColor(2, 24'hFF4040);
    step(400);

    $display("[TB] reset mid grant");
    resetPulse();
    step(20);

    $display("[TB] random traffic");
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        idx = $urandom_range(0, NR - 1);
        req[idx] = ~req[idx];
      end
      if ($urandom_range(0, 63) == 0) setColor($urandom_range(0, NR - 1), 24'($urandom()));
      if ($urandom_range(0, 63) == 0) begin
        idx = $urandom_range(0, NR - 1);
        blink[idx] = ~blink[idx];
      end
      if ($urandom_range(0, 999) == 0) resetPulse();
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rgb_led_arbiter.md
Name: rgb_led_arbiter

Overview:
- Shares the single on-board RGB LED (active-low pins, 12 MHz clock) between NUM_REQ status requesters.
- Grants the LED to one requester at a time using fixed priority, a minimum hold time and an off-gap between owners.
- Drives each channel with 8-bit PWM and optional per-requester blink.
- Sits at the top level between status sources (heartbeat, error, activity) and the LED pins.

Parameters:
- NUM_REQ, 3: number of requesters; index 0 has highest priority.
- PWM_DIV, 47: clock cycles per PWM counter step (about 1 kHz PWM frame at 12 MHz).
- BLINK_CYC, 6000000: cycles per blink half-period (0.5 s).
- MIN_HOLD, 1200000: minimum cycles an owner keeps the LED before preemption (100 ms).
- GAP_CYC, 12000: LED-off cycles between owners (1 ms).

Ports:
- CLK  in  1  system clock, 12 MHz.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NUM_REQ  level request per requester.
- COLOR  in  24*NUM_REQ  per-requester {R[7:0],G[7:0],B[7:0]} duty; requester i occupies bits [24i+23:24i].
- BLINK  in  NUM_REQ  1 = blink owner's colour.
- GNT  out  NUM_REQ  one-hot current owner; all-zero when none.
- BUSY  out  1  any owner granted.
- LED_R  out  1  red pin, active-low (1 = off).
- LED_G  out  1  green pin, active-low.
- LED_B  out  1  blue pin, active-low.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N. All state is cleared immediately on RST_N low.
- Reset values: GNT=0, BUSY=0, LED_R=LED_G=LED_B=1 (off), state=IDLE, all counters 0, blink phase=1 (visible).
- All outputs are registered.
- State IDLE:
  - If any REQ bit is high, the next state is GRANT and the owner is the lowest set index.
  - GNT and BUSY assert on the cycle after REQ is first sampled high.
  - The hold counter and blink counter clear on entry.
- State GRANT:
  - The hold counter increments each cycle and saturates at MIN_HOLD.
  - If REQ[owner] drops (any time, including before MIN_HOLD): next state is GAP; GNT and BUSY clear on the next cycle.
  - If hold has reached MIN_HOLD and a higher-priority REQ is high: next state is GAP (preemption).
  - A lower-priority REQ never preempts.
  - Simultaneous owner drop and higher request: go to GAP.
- State GAP:
  - LEDs off, GNT=0. Counts GAP_CYC cycles, then returns to IDLE and re-arbitrates the same cycle.
  - Requests are not latched: a requester that dropped during GAP is not granted.
- PWM:
  - Prescaler counts 0..PWM_DIV-1; the 8-bit frame counter advances when the prescaler wraps.
  - The frame counter runs freely in all states.
  - A channel is lit when frame counter < duty. Duty 0 means never lit; duty 255 means lit 255/256 of the frame.
- Duty latching:
  - The owner's COLOR is latched into duty registers at grant, and at every frame-counter wrap 255->0.
  - COLOR changes mid-frame therefore take effect at the next frame.
- Blink:
  - The blink counter counts 0..BLINK_CYC-1 during GRANT, toggling the phase at wrap. It restarts with phase=1 at each grant.
  - If BLINK[owner]=1 and phase=0, all LEDs are off.
  - BLINK is sampled live.
- LED pin = NOT(state==GRANT AND channel lit AND blink visible), registered. This gives one cycle from the internal condition to the pin.
- Reset mid-grant: pins go to 1 immediately; no grant resumes until REQ is sampled after release.
- Width rules:
  - Counters are sized with clog2(param+1).
  - MIN_HOLD=0 allows immediate preemption.
  - GAP_CYC=0 is not supported; the minimum is 1.

Decomposition:
- Package rgb_led_pkg holds:
  - state enum {IDLE, GRANT, GAP};
  - color_t struct {r,g,b} of 8 bits each;
  - constant LED_OFF=1'b1;
  - function prio_pick (lowest-set-index one-hot).
- Sub-module rgb_pwm:
  - contains the prescaler, frame counter, 3 duty registers with wrap-latch, and 3 comparators;
  - outputs raw active-high lit[2:0] and frame_wrap.

Test Plan (PWM_DIV=1, BLINK_CYC=16, MIN_HOLD=20, GAP_CYC=4, NUM_REQ=3):
- Reset release with REQ=0 -> GNT=000, BUSY=0, LEDs=111 held for 1000 cycles; assert RST_N low mid-GRANT -> LEDs=111 and GNT=000 without waiting for a clock edge.
- REQ=010, COLOR1={FF,00,80}, BLINK=0 -> GNT=010 one cycle later; per 256-step frame LED_R low 255 steps, LED_G never low, LED_B low 128 steps.
- Owner 2 granted, REQ0 raised at hold count 5 -> GNT stays 100 until hold=20, then 000 for 4 cycles, then 001.
- Owner 0 granted, REQ2 raised -> no preemption; drop REQ0 -> GNT=000 for 4 cycles, then 100.
- BLINK[owner]=1, duty FF,FF,FF -> LEDs lit 16 cycles, then 111 for 16 cycles, repeating; the first phase after grant is lit.
- Change COLOR of owner mid-frame from R=00 to R=FF -> LED_R stays high until the frame wrap, then follows the new duty.
